// File: rtl/d_stage.sv
// -----------------------------------------------------------------------------
// d_stage
//
// Decode stage of the five-stage MIPS pipeline. Holds the F/D pipeline
// register and the 32x32 general register file (GRF), resolves
// beq/bne/j/jal/jr in decode and drives the fetch stage's next-PC controls.
// Branches have one delay slot: the instruction already in F when a branch
// sits in D always executes.
//
// Parameters:
//   RESET_PC    PC value loaded into the F/D register on reset
//
// Ports:
//   clk_D       in   1   stage clock, rising-edge
//   reset_D     in   1   synchronous active-high reset (F/D register and GRF)
//   Instr_F     in  32   instruction from fetch
//   PC_F        in  32   PC of Instr_F
//   Stall_D     in   1   hazard stall: F/D holds, NpcOp_D forced to 00
//   RegWrite_W  in   1   GRF write enable from writeback
//   A3_W        in   5   GRF write address
//   WD_W        in  32   GRF write data
//   FwdEn_M     in   1   M-stage result valid for forwarding
//   FwdA3_M     in   5   M-stage destination register
//   FwdData_M   in  32   M-stage result
//   Instr_D     out 32   registered instruction
//   PC_D        out 32   registered PC
//   RD1_D       out 32   forwarded rs value
//   RD2_D       out 32   forwarded rt value
//   NpcOp_D     out  2   next-PC select to fetch
//                        (00 PC+4, 01 branch, 10 jump, 11 register)
//   IMM_D       out 26   Instr_D[25:0]
//   RA_D        out 32   jr target (equal to RD1_D)
// -----------------------------------------------------------------------------
module d_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk_D,
    input  logic        reset_D,
    input  logic [31:0] Instr_F,
    input  logic [31:0] PC_F,
    input  logic        Stall_D,
    input  logic        RegWrite_W,
    input  logic [4:0]  A3_W,
    input  logic [31:0] WD_W,
    input  logic        FwdEn_M,
    input  logic [4:0]  FwdA3_M,
    input  logic [31:0] FwdData_M,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] RD1_D,
    output logic [31:0] RD2_D,
    output logic [1:0]  NpcOp_D,
    output logic [25:0] IMM_D,
    output logic [31:0] RA_D
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FN_JR      = 6'b001000;

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_REG    = 2'b11;

    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] regs [32];

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        grf_we;
    logic [31:0] grf_rs;
    logic [31:0] grf_rt;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [1:0]  npc_op;

    // F/D pipeline register: reset to a nop at RESET_PC, hold on stall.
    always_ff @(posedge clk_D) begin
        if (reset_D) begin
            instr_q <= 32'h0000_0000;
            pc_q    <= RESET_PC;
        end else if (!Stall_D) begin
            instr_q <= Instr_F;
            pc_q    <= PC_F;
        end
    end

    // Writes to $0 are dropped so entry 0 stays zero; reads of $0 are
    // also forced to zero below, so entry 0 is never relied upon.
    assign grf_we = RegWrite_W && (A3_W != 5'd0);

    // Register file: cleared by reset, written on the rising edge.
    always_ff @(posedge clk_D) begin
        if (reset_D) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0000_0000;
            end
        end else if (grf_we) begin
            regs[A3_W] <= WD_W;
        end
    end

    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign funct  = instr_q[5:0];

    // Write-first bypass so a same-cycle W write is visible to decode.
    assign grf_rs = (grf_we && (A3_W == rs)) ? WD_W : regs[rs];
    assign grf_rt = (grf_we && (A3_W == rt)) ? WD_W : regs[rt];

    // Operand selection: $0 first, then M forwarding (newer than W),
    // then the bypassed GRF read.
    always_comb begin
        rd1 = grf_rs;
        if (rs == 5'd0) begin
            rd1 = 32'h0000_0000;
        end else if (FwdEn_M && (FwdA3_M == rs)) begin
            rd1 = FwdData_M;
        end
    end

    always_comb begin
        rd2 = grf_rt;
        if (rt == 5'd0) begin
            rd2 = 32'h0000_0000;
        end else if (FwdEn_M && (FwdA3_M == rt)) begin
            rd2 = FwdData_M;
        end
    end

    // Next-PC decode. A stalled instruction must not redirect fetch,
    // since its operands may still be stale; it is re-decoded on release.
    always_comb begin
        npc_op = NPC_SEQ;
        if (!Stall_D) begin
            case (opcode)
                OP_BEQ:     npc_op = (rd1 == rd2) ? NPC_BRANCH : NPC_SEQ;
                OP_BNE:     npc_op = (rd1 != rd2) ? NPC_BRANCH : NPC_SEQ;
                OP_J,
                OP_JAL:     npc_op = NPC_JUMP;
                OP_SPECIAL: npc_op = (funct == FN_JR) ? NPC_REG : NPC_SEQ;
                default:    npc_op = NPC_SEQ;
            endcase
        end
    end

    assign Instr_D = instr_q;
    assign PC_D    = pc_q;
    assign RD1_D   = rd1;
    assign RD2_D   = rd2;
    assign NpcOp_D = npc_op;
    assign IMM_D   = instr_q[25:0];
    assign RA_D    = rd1;

endmodule

// File: tb/tb_d_stage.sv
// -----------------------------------------------------------------------------
// tb_d_stage
//
// Directed self-checking bench for d_stage. Inputs change 1 time unit after
// the rising edge; outputs are compared mid-cycle, away from the edge.
// -----------------------------------------------------------------------------
module tb_d_stage;

    logic        clk_D;
    logic        reset_D;
    logic [31:0] Instr_F;
    logic [31:0] PC_F;
    logic        Stall_D;
    logic        RegWrite_W;
    logic [4:0]  A3_W;
    logic [31:0] WD_W;
    logic        FwdEn_M;
    logic [4:0]  FwdA3_M;
    logic [31:0] FwdData_M;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic [31:0] RD1_D;
    logic [31:0] RD2_D;
    logic [1:0]  NpcOp_D;
    logic [25:0] IMM_D;
    logic [31:0] RA_D;

    int checkCount = 0;
    int errorCount = 0;

    d_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk_D      (clk_D),
        .reset_D    (reset_D),
        .Instr_F    (Instr_F),
        .PC_F       (PC_F),
        .Stall_D    (Stall_D),
        .RegWrite_W (RegWrite_W),
        .A3_W       (A3_W),
        .WD_W       (WD_W),
        .FwdEn_M    (FwdEn_M),
        .FwdA3_M    (FwdA3_M),
        .FwdData_M  (FwdData_M),
        .Instr_D    (Instr_D),
        .PC_D       (PC_D),
        .RD1_D      (RD1_D),
        .RD2_D      (RD2_D),
        .NpcOp_D    (NpcOp_D),
        .IMM_D      (IMM_D),
        .RA_D       (RA_D)
    );

    initial clk_D = 1'b0;
    always #5 clk_D = ~clk_D;

    // Instruction encoders
    function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Single comparison point: counts and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Advance one clock and step just past the edge
    task automatic tick();
        @(posedge clk_D);
        #1;
    endtask

    // Present a new instruction/PC pair on the fetch side
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc);
        Instr_F = instr;
        PC_F    = pc;
    endtask

    // Commit one GRF write through the W port across one edge
    task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
        RegWrite_W = 1'b1;
        A3_W       = addr;
        WD_W       = data;
        tick();
        RegWrite_W = 1'b0;
        A3_W       = 5'd0;
        WD_W       = 32'h0;
    endtask

    logic [31:0] addI;
    logic [31:0] addZ;
    logic [31:0] beqI;
    logic [31:0] bneI;
    logic [31:0] jI;
    logic [31:0] jalI;
    logic [31:0] jrI;
    logic [31:0] afterStall;

    initial begin
        addI  = rType(5'd5, 5'd0, 5'd6, 6'b100000);
        addZ  = rType(5'd0, 5'd5, 5'd7, 6'b100000);
        beqI  = iType(6'b000100, 5'd1, 5'd2, 16'h0004);
        bneI  = iType(6'b000101, 5'd3, 5'd0, 16'h0002);
        jI    = {6'b000010, 26'h000_0C04};
        jalI  = {6'b000011, 26'h012_3456};
        jrI   = rType(5'd31, 5'd0, 5'd0, 6'b001000);
        afterStall = iType(6'b001101, 5'd1, 5'd2, 16'h00AA);

        reset_D    = 1'b1;
        Stall_D    = 1'b0;
        RegWrite_W = 1'b0;
        A3_W       = 5'd0;
        WD_W       = 32'h0;
        FwdEn_M    = 1'b0;
        FwdA3_M    = 5'd0;
        FwdData_M  = 32'h0;
        applyStimulus(32'hFFFF_FFFF, 32'h0000_1234);

        // Reset
        tick();
        checkOutput("reset_instr", Instr_D, 32'h0);
        checkOutput("reset_pc", PC_D, 32'h0000_3000);
        checkOutput("reset_npc", {30'd0, NpcOp_D}, 32'd0);
        checkOutput("reset_rd1", RD1_D, 32'h0);
        checkOutput("reset_rd2", RD2_D, 32'h0);
        reset_D = 1'b0;

        // GRF write-first bypass
        applyStimulus(addI, 32'h0000_3004);
        tick();
        checkOutput("add_instr", Instr_D, addI);
        checkOutput("add_pc", PC_D, 32'h0000_3004);
        RegWrite_W = 1'b1; A3_W = 5'd5; WD_W = 32'hDEAD_BEEF;
        #1;
        checkOutput("bypass_rd1", RD1_D, 32'hDEAD_BEEF);
        checkOutput("add_npc", {30'd0, NpcOp_D}, 32'd0);
        tick();
        RegWrite_W = 1'b0; A3_W = 5'd0; WD_W = 32'h0;
        #1;
        checkOutput("stored_rd1", RD1_D, 32'hDEAD_BEEF);

        // Writes to $0 are discarded
        applyStimulus(addZ, 32'h0000_3008);
        tick();
        RegWrite_W = 1'b1; A3_W = 5'd0; WD_W = 32'h0000_1234;
        #1;
        checkOutput("zero_bypass", RD1_D, 32'h0);
        checkOutput("rt_read", RD2_D, 32'hDEAD_BEEF);
        tick();
        RegWrite_W = 1'b0; WD_W = 32'h0;
        #1;
        checkOutput("zero_stored", RD1_D, 32'h0);

        // beq taken / not taken
        applyStimulus(beqI, 32'h0000_3010);
        writeReg(5'd1, 32'd7);
        writeReg(5'd2, 32'd7);
        checkOutput("beq_taken", {30'd0, NpcOp_D}, 32'd1);
        checkOutput("beq_imm", {16'd0, IMM_D[15:0]}, 32'h0000_0004);
        writeReg(5'd2, 32'd8);
        checkOutput("beq_not_taken", {30'd0, NpcOp_D}, 32'd0);

        // M forwarding beats W bypass
        writeReg(5'd3, 32'd1);
        applyStimulus(bneI, 32'h0000_3014);
        tick();
        FwdEn_M = 1'b1; FwdA3_M = 5'd3; FwdData_M = 32'd9;
        RegWrite_W = 1'b1; A3_W = 5'd3; WD_W = 32'd5;
        #1;
        checkOutput("fwd_rd1", RD1_D, 32'd9);
        checkOutput("bne_taken", {30'd0, NpcOp_D}, 32'd1);
        RegWrite_W = 1'b0; FwdEn_M = 1'b0;
        #1;
        checkOutput("grf_rd1", RD1_D, 32'd1);
        FwdEn_M = 1'b1; FwdA3_M = 5'd0; FwdData_M = 32'd55;
        #1;
        checkOutput("fwd_zero_rd2", RD2_D, 32'h0);
        FwdEn_M = 1'b0; FwdA3_M = 5'd0; FwdData_M = 32'h0;

        // Jumps
        applyStimulus(jI, 32'h0000_3020);
        tick();
        checkOutput("j_npc", {30'd0, NpcOp_D}, 32'd2);
        checkOutput("j_imm", {6'd0, IMM_D}, 32'h0000_0C04);
        applyStimulus(jalI, 32'h0000_3024);
        tick();
        checkOutput("jal_npc", {30'd0, NpcOp_D}, 32'd2);
        checkOutput("jal_imm", {6'd0, IMM_D}, 32'h0012_3456);
        applyStimulus(jrI, 32'h0000_3028);
        writeReg(5'd31, 32'h0000_3010);
        checkOutput("jr_npc", {30'd0, NpcOp_D}, 32'd3);
        checkOutput("jr_ra", RA_D, 32'h0000_3010);

        // Stall hold for three cycles
        Stall_D = 1'b1;
        #1;
        checkOutput("stall_npc", {30'd0, NpcOp_D}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h1000_0000 + i, 32'h0000_4000 + 4 * i);
            tick();
            checkOutput("stall_instr", Instr_D, jrI);
            checkOutput("stall_pc", PC_D, 32'h0000_3028);
            checkOutput("stall_npc_hold", {30'd0, NpcOp_D}, 32'd0);
        end
        Stall_D = 1'b0;
        #1;
        checkOutput("release_redecode", {30'd0, NpcOp_D}, 32'd3);
        applyStimulus(afterStall, 32'h0000_302C);
        tick();
        checkOutput("release_instr", Instr_D, afterStall);
        checkOutput("release_pc", PC_D, 32'h0000_302C);

        // Reset during a stall clears F/D and the GRF
        Stall_D = 1'b1;
        reset_D = 1'b1;
        tick();
        reset_D = 1'b0;
        Stall_D = 1'b0;
        #1;
        checkOutput("midreset_instr", Instr_D, 32'h0);
        checkOutput("midreset_pc", PC_D, 32'h0000_3000);
        checkOutput("midreset_npc", {30'd0, NpcOp_D}, 32'd0);
        applyStimulus(jrI, 32'h0000_3000);
        tick();
        checkOutput("midreset_ra", RA_D, 32'h0);
        checkOutput("midreset_jr", {30'd0, NpcOp_D}, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
